// File: rtl/pass_pkg.sv
// Shared definitions for the pass-lock controller: FSM state encoding and small
// elaboration-time helpers.
package pass_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    RIGHT   = 3'd3,
    WRONG   = 3'd4,
    LOCKOUT = 3'd5
  } state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// LED blinker: while enabled the LED starts at 1 and toggles every BLINK_DIV cycles.
// 'en' is the enable for the coming cycle, so the LED register lines up with the FSM state register.
module blink_gen #(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic led
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          led_q, led_d;

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    led_d = led_q;
    if (!en) begin
      cnt_d = '0;
      act_d = 1'b0;
      led_d = 1'b0;
    end else if (!act_q) begin
      cnt_d = '0;
      act_d = 1'b1;
      led_d = 1'b1;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d = '0;
      led_d = ~led_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/pass_lock_ctrl.sv
// Barrier pass-code controller: digit entry with timeout, code check and LED feedback.
// Define PASS_LOCKOUT_EN to add the try counter and the LOCKOUT state.
module pass_lock_ctrl
  import pass_pkg::*;
#(
  parameter int                                DIGIT_W      = 2,
  parameter int                                NUM_DIGITS   = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = 8'b01_10_11_00,
  parameter int                                TIMEOUT_CYC  = 16,
  parameter int                                MAX_TRIES    = 3,
  parameter int                                LOCK_CYC     = 64,
  parameter int                                BLINK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sensor_entrance,
  input  logic                          sensor_exit,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          code_load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_in,
  output logic                          green_led,
  output logic                          red_led,
  output logic                          locked,
  output logic [2:0]                    state_o
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W  = $clog2(max_i(TIMEOUT_CYC, LOCK_CYC) + 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, idx;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                miss_q, miss_d, miss_base, fail;
  logic                green_en, red_en, red_blink;

`ifdef PASS_LOCKOUT_EN
  localparam int TRY_W = max_i(2, $clog2(MAX_TRIES + 1));
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic                lock_q, lock_d;
`endif

  // Digit 0 is the most-significant slice of the stored code.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [CNT_W-1:0]  i);
    logic [CODE_W-1:0] sh;
    sh = code >> (DIGIT_W * (NUM_DIGITS - 1 - int'(i)));
    return sh[DIGIT_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    miss_d    = miss_q;
    fail      = 1'b0;
    // A digit in WRONG restarts entry as digit 1 with a clean mismatch flag.
    idx       = (state_q == ENTRY) ? cnt_q : '0;
    miss_base = (state_q == ENTRY) ? miss_q : 1'b0;
`ifdef PASS_LOCKOUT_EN
    tries_d   = tries_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tmr_d  = '0;
        miss_d = 1'b0;
        if (code_load) code_d = code_in;
        if (sensor_entrance) state_d = ENTRY;
      end
      ENTRY, WRONG: begin
        if (digit_valid) begin
          miss_d  = miss_base | (digit != code_digit(code_q, idx));
          cnt_d   = idx + 1'b1;
          tmr_d   = '0;
          state_d = (idx == CNT_W'(NUM_DIGITS - 1)) ? CHECK : ENTRY;
        end else if (state_q == ENTRY) begin
          if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) fail = 1'b1;
          else tmr_d = tmr_q + 1'b1;
        end
      end
      CHECK: begin
        if (miss_q) fail = 1'b1;
        else state_d = RIGHT;
      end
      RIGHT: begin
`ifdef PASS_LOCKOUT_EN
        tries_d = '0;
`endif
        if (sensor_exit) state_d = IDLE;
      end
`ifdef PASS_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCK_CYC - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
          tries_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (fail) begin
`ifdef PASS_LOCKOUT_EN
      tries_d = tries_q + 1'b1;
      if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
        state_d = LOCKOUT;
        tmr_d   = '0;
      end else begin
        state_d = WRONG;
      end
`else
      state_d = WRONG;
`endif
    end
  end

`ifdef PASS_LOCKOUT_EN
  assign lock_d = (state_d == LOCKOUT);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      miss_q  <= 1'b0;
`ifdef PASS_LOCKOUT_EN
      tries_q <= '0;
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      miss_q  <= miss_d;
`ifdef PASS_LOCKOUT_EN
      tries_q <= tries_d;
      lock_q  <= lock_d;
`endif
    end
  end

  // Blinkers look at the next state so their LED flops change together with state_q.
  assign green_en = (state_d == RIGHT);
  assign red_en   = (state_d == WRONG);

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_green_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (green_en),
    .led     (green_led)
  );

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_red_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (red_en),
    .led     (red_blink)
  );

`ifdef PASS_LOCKOUT_EN
  assign red_led = red_blink | lock_q;
  assign locked  = lock_q;
`else
  assign red_led = red_blink;
  assign locked  = 1'b0;
`endif

  assign state_o = state_q;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Scoreboard bench for pass_lock_ctrl: a cycle-level reference model predicts the
// outputs after every clock; a monitor pops and compares them one cycle later.
module tb_pass_lock_ctrl;

  localparam int DW = 2;
  localparam int ND = 4;
  localparam int CW = ND * DW;
  localparam int TO = 16;
  localparam int MT = 3;
  localparam int LC = 64;
  localparam int BD = 4;
  localparam logic [CW-1:0] DEF = 8'b01_10_11_00;

  localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_RIGHT = 3, S_WRONG = 4, S_LOCK = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ent = 1'b0, ex = 1'b0, dv = 1'b0, cl = 1'b0;
  logic [DW-1:0] dig = '0;
  logic [CW-1:0] cin = '0;
  logic          green, red, locked;
  logic [2:0]    st_o;

  always #5 clk = ~clk;

  pass_lock_ctrl #(
    .DIGIT_W(DW), .NUM_DIGITS(ND), .DEFAULT_CODE(DEF), .TIMEOUT_CYC(TO),
    .MAX_TRIES(MT), .LOCK_CYC(LC), .BLINK_DIV(BD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (ent),
    .sensor_exit     (ex),
    .digit_valid     (dv),
    .digit           (dig),
    .code_load       (cl),
    .code_in         (cin),
    .green_led       (green),
    .red_led         (red),
    .locked          (locked),
    .state_o         (st_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       g;
    logic       r;
    logic       l;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference model: entered digits kept as a list, timers as plain counts.
  int            m_st, m_idle, m_tries, m_lock, m_age;
  logic [DW-1:0] m_dig[$];
  logic [CW-1:0] m_code;

  function automatic logic [DW-1:0] code_digit(input logic [CW-1:0] c, input int i);
    logic [CW-1:0] s;
    s = c >> ((ND - 1 - i) * DW);
    return s[DW-1:0];
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_idle = 0; m_tries = 0; m_lock = 0; m_age = 0;
    m_dig.delete();
    m_code = DEF;
  endtask

  task automatic model_fail(output int nxt);
    m_tries++;
`ifdef PASS_LOCKOUT_EN
    if (m_tries == MT) begin
      nxt = S_LOCK;
      m_lock = LC;
    end else begin
      nxt = S_WRONG;
    end
`else
    nxt = S_WRONG;
`endif
  endtask

  task automatic model_step();
    int prev, nxt;
    bit ok;
    prev = m_st;
    nxt  = m_st;
    case (m_st)
      S_IDLE: begin
        if (cl) m_code = cin;
        if (ent) begin nxt = S_ENTRY; m_dig.delete(); m_idle = 0; end
      end
      S_ENTRY: begin
        if (dv) begin
          m_dig.push_back(dig);
          m_idle = 0;
          if (m_dig.size() == ND) nxt = S_CHECK;
        end else begin
          m_idle++;
          if (m_idle == TO) model_fail(nxt);
        end
      end
      S_CHECK: begin
        ok = 1'b1;
        foreach (m_dig[i]) if (m_dig[i] != code_digit(m_code, i)) ok = 1'b0;
        if (ok) begin nxt = S_RIGHT; m_tries = 0; end
        else model_fail(nxt);
      end
      S_RIGHT: if (ex) nxt = S_IDLE;
      S_WRONG: begin
        if (dv) begin m_dig.delete(); m_dig.push_back(dig); m_idle = 0; nxt = S_ENTRY; end
      end
      S_LOCK: begin
        m_lock--;
        if (m_lock == 0) begin nxt = S_IDLE; m_tries = 0; end
      end
      default: nxt = S_IDLE;
    endcase
    m_age = (nxt == prev) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   on;
    on   = ((m_age / BD) % 2) == 0;
    e.st = 3'(m_st);
    e.g  = (m_st == S_RIGHT) && on;
    e.r  = ((m_st == S_WRONG) && on) || (m_st == S_LOCK);
    e.l  = (m_st == S_LOCK);
    return e;
  endfunction

  task automatic cycle(input logic e, input logic x, input logic v, input logic [DW-1:0] d,
                       input logic c, input logic [CW-1:0] ci);
    @(negedge clk);
    ent = e; ex = x; dv = v; dig = d; cl = c; cin = ci;
    model_step();
    sbq.push_back(model_out());
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0);
  endtask

  task automatic key(input logic [DW-1:0] d);
    cycle(0, 0, 1, d, 0, '0);
  endtask

  task automatic enter4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock.
  task automatic do_reset();
    @(negedge clk);
    ent = 0; ex = 0; dv = 0; dig = '0; cl = 0; cin = '0;
    #1 reset_n = 1'b0;
    #1;
    n_chk++;
    if (st_o == 3'd0 && !green && !red && !locked) n_pass++;
    else $display("FAIL reset_outputs: got state=%0d g=%b r=%b l=%b, want state=0 g=0 r=0 l=0",
                  st_o, green, red, locked);
    model_reset();
    #1 reset_n = 1'b1;
    model_step();
    sbq.push_back(model_out());
  endtask

  // Monitor: one prediction per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_chk++;
        if (st_o == e.st && green == e.g && red == e.r && locked == e.l) n_pass++;
        else $display("FAIL outputs cyc%0d: got state=%0d g=%b r=%b l=%b, want state=%0d g=%b r=%b l=%b",
                      cyc, st_o, green, red, locked, e.st, e.g, e.r, e.l);
      end
    end
  end

  initial begin
    logic e, x, v, c;
    logic [DW-1:0] d;
    model_reset();
    do_reset();

    // Correct code, green blinking, exit.
    cycle(1, 0, 0, '0, 0, '0);
    enter4(2'd1, 2'd2, 2'd3, 2'd0);
    idle_n(12);
    cycle(1, 1, 0, '0, 0, '0);
    idle_n(2);

    // Wrong code then correct retry from WRONG.
    cycle(1, 0, 0, '0, 0, '0);
    enter4(2'd1, 2'd2, 2'd3, 2'd1);
    idle_n(9);
    enter4(2'd1, 2'd2, 2'd3, 2'd0);
    idle_n(3);
    cycle(0, 1, 0, '0, 0, '0);

    // Timeout after 16 idle cycles.
    cycle(1, 0, 0, '0, 0, '0);
    key(2'd1);
    idle_n(16);
    idle_n(2);
    enter4(2'd1, 2'd2, 2'd3, 2'd0);
    idle_n(1);
    cycle(0, 1, 0, '0, 0, '0);

    // Digits on idle cycle 15 and on the boundary cycle 16 both keep ENTRY.
    cycle(1, 0, 0, '0, 0, '0);
    key(2'd1);
    idle_n(14);
    key(2'd2);
    idle_n(15);
    key(2'd3);
    key(2'd0);
    idle_n(2);
    cycle(0, 1, 0, '0, 0, '0);

    // Three consecutive failures, then digits during lockout (or WRONG).
    cycle(1, 0, 0, '0, 0, '0);
    key(2'd1);
    idle_n(16);
    enter4(2'd0, 2'd0, 2'd0, 2'd0);
    idle_n(2);
    enter4(2'd0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 70; i++) cycle(0, 0, 1, 2'(i), 0, '0);
    idle_n(4);
    do_reset();

    // Code change in IDLE, ignored load in ENTRY, reset mid-entry restores default.
    cycle(0, 0, 0, '0, 1, 8'hFF);
    cycle(1, 0, 0, '0, 0, '0);
    enter4(2'd3, 2'd3, 2'd3, 2'd3);
    idle_n(2);
    cycle(0, 1, 0, '0, 0, '0);
    cycle(1, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 1, 8'h00);
    enter4(2'd3, 2'd3, 2'd3, 2'd3);
    idle_n(2);
    cycle(0, 1, 0, '0, 0, '0);
    cycle(1, 0, 0, '0, 0, '0);
    key(2'd1);
    do_reset();
    cycle(1, 0, 0, '0, 0, '0);
    enter4(2'd1, 2'd2, 2'd3, 2'd0);
    idle_n(2);
    cycle(0, 1, 0, '0, 0, '0);

    // Randomized traffic, digits biased toward the stored code.
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 3) == 0);
      x = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 15) == 0);
      d = DW'($urandom_range(0, (1 << DW) - 1));
      if (m_st == S_ENTRY && m_dig.size() < ND && $urandom_range(0, 3) != 0)
        d = code_digit(m_code, m_dig.size());
      else if (m_st == S_WRONG && $urandom_range(0, 3) != 0)
        d = code_digit(m_code, 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(e, x, v, d, c, CW'($urandom_range(0, (1 << CW) - 1)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pass_lock_ctrl.md
PASS_LOCK_CTRL -- requirements
Module: pass_lock_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_W, default 2, bits per entered digit.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, digits per code.
REQ-003 SHALL have parameter DEFAULT_CODE, default 8'b01_10_11_00, code after reset; width NUM_DIGITS*DIGIT_W.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, idle cycles allowed between digits.
REQ-005 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes before lockout.
REQ-006 SHALL have parameter LOCK_CYC, default 64, lockout duration in cycles.
REQ-007 SHALL have parameter BLINK_DIV, default 4, LED half-period in cycles.
REQ-008 Ports: clk, in, 1, clock; reset_n, in, 1, reset, asynchronous, active-low.
REQ-009 Ports: sensor_entrance, in, 1, vehicle present; sensor_exit, in, 1, vehicle passed.
REQ-010 Ports: digit_valid, in, 1, digit strobe; digit, in, DIGIT_W, digit value.
REQ-011 Ports: code_load, in, 1, store code_in; code_in, in, NUM_DIGITS*DIGIT_W, new code.
REQ-012 Ports: green_led, out, 1; red_led, out, 1; locked, out, 1; state_o, out, 3, current state encoding.

Function
REQ-013 SHALL implement states IDLE, ENTRY, CHECK, RIGHT, WRONG, LOCKOUT, registered on clk.
REQ-014 IDLE: sensor_entrance=1 -> ENTRY; digit count and timeout timer cleared; digits in IDLE ignored.
REQ-015 code_load SHALL update the stored code only in IDLE; ignored in all other states.
REQ-016 ENTRY: each digit_valid=1 cycle accepts one digit; first accepted digit compares against the most-significant DIGIT_W slice of the code.
REQ-017 ENTRY: accepting digit NUM_DIGITS -> CHECK on the next edge; CHECK lasts exactly one cycle, then RIGHT if all digits match, else WRONG.
REQ-018 ENTRY: timer counts cycles since entry or the last accepted digit; reaching TIMEOUT_CYC with no digit -> WRONG. A digit accepted in that same cycle wins and resets the timer.
REQ-019 RIGHT: green_led blinks, red_led=0, try counter cleared; sensor_exit=1 -> IDLE, and also wins when sensor_entrance=1 in the same cycle.
REQ-020 WRONG: red_led blinks, green_led=0; digit_valid=1 -> ENTRY with that digit accepted as digit 1.
REQ-021 Blink: LED toggles every BLINK_DIV cycles, starts at 1 on the first cycle of the blinking state, and is 0 in states that do not drive it.
REQ-022 IDLE, ENTRY and CHECK SHALL drive green_led=0 and red_led=0.

Reset
REQ-023 reset_n=0 SHALL immediately force state IDLE, all LEDs 0, locked=0, all counters 0 and stored code=DEFAULT_CODE, including mid-entry or mid-lockout.
REQ-024 The first state change SHALL occur on the first clk rising edge after reset_n deasserts.

Configuration
REQ-025 Macro PASS_LOCKOUT_EN defined: a 2-bit-min try counter increments on each CHECK->WRONG or timeout->WRONG transition; the MAX_TRIES-th such transition goes to LOCKOUT instead of WRONG.
REQ-026 LOCKOUT: red_led=1 steady, locked=1, all digits ignored; after LOCK_CYC cycles -> IDLE with the try counter cleared.
REQ-027 Macro undefined: no try counter and no LOCKOUT state; locked is tied to 0 and every failure goes to WRONG.

Structure
REQ-028 Package pass_pkg SHALL hold the state enum typedef and its encodings: IDLE=0, ENTRY=1, CHECK=2, RIGHT=3, WRONG=4, LOCKOUT=5.
REQ-029 Sub-module blink_gen SHALL hold the parameter BLINK_DIV, with enable input and LED output; two instances, one for green and one for red.

Verification (defaults, code 01,10,11,00)
REQ-030 Correct entry: entrance=1, then digits 1,2,3,0 on consecutive cycles -> CHECK one cycle later, RIGHT next; green toggles every 4 cycles; exit=1 -> IDLE with LEDs 0.
REQ-031 Wrong entry: digits 1,2,3,1 -> WRONG with red blinking; digits 1,2,3,0 -> RIGHT.
REQ-032 Timeout: entrance, then digit 1, then 16 idle cycles -> WRONG; a digit on cycle 15 keeps ENTRY.
REQ-033 Lockout (PASS_LOCKOUT_EN): three wrong codes -> LOCKOUT with locked=1 and red=1 steady; digits ignored for 64 cycles -> IDLE; rebuild without the macro so that a 3rd failure -> WRONG.
REQ-034 Code change and reset: code_load=1 with 8'hFF in IDLE -> digits 3,3,3,3 pass; code_load in ENTRY is ignored; reset_n=0 mid-ENTRY -> IDLE and code reverts to DEFAULT_CODE.
